// File: rtl/data_memory_controller.sv
// Word-addressed data memory with byte-masked stores and fixed-latency loads.
// Registered handshake: a one-cycle ready pulse per read, error on out-of-range.
module data_memory_controller #(
    parameter int DEPTH        = 1024,
    parameter int READ_LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_write_data,
    output logic [31:0] data_memory_interface_read_data,
    output logic        data_memory_interface_ready,
    output logic        data_memory_interface_error
);

    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ_WAIT,
        RESPOND,
        DRAIN
    } fsm_t;

    fsm_t        fsm_q;
    logic [3:0]  cnt_q;
    logic [IW-1:0] idx_q;
    logic        oor_q;
    logic [31:0] rdata_q;
    logic        ready_q;
    logic        error_q;

    logic [31:0] mem [DEPTH];

    logic [29:0]   word_index;
    logic [IW-1:0] idx;
    logic          oor;
    logic          is_write;
    logic          wr_commit;
    logic          unused_addr_bits;

    assign word_index = data_memory_interface_address[31:2];
    assign idx        = word_index[IW-1:0];
    assign is_write   = data_memory_interface_state;
    assign unused_addr_bits = ^data_memory_interface_address[1:0];

    // Range check spans the whole word index, not just the decoded bits.
    assign oor = ({2'b00, word_index} >= 32'(DEPTH));

    assign wr_commit = reset
                     && (fsm_q == IDLE)
                     && data_memory_interface_enable
                     && is_write
                     && !oor;

    // Memory array carries no reset so contents survive a core reset.
    always_ff @(posedge clk) begin
        if (wr_commit) begin
            if (data_memory_interface_frame_mask[3])
                mem[idx][7:0]   <= data_memory_interface_write_data[7:0];
            if (data_memory_interface_frame_mask[2])
                mem[idx][15:8]  <= data_memory_interface_write_data[15:8];
            if (data_memory_interface_frame_mask[1])
                mem[idx][23:16] <= data_memory_interface_write_data[23:16];
            if (data_memory_interface_frame_mask[0])
                mem[idx][31:24] <= data_memory_interface_write_data[31:24];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            fsm_q   <= IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            error_q <= 1'b0;
            unique case (fsm_q)
                IDLE: begin
                    if (data_memory_interface_enable) begin
                        if (is_write) begin
                            error_q <= oor;
                        end else begin
                            idx_q <= idx;
                            oor_q <= oor;
                            cnt_q <= 4'(READ_LATENCY - 1);
                            fsm_q <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (!data_memory_interface_enable) begin
                        cnt_q <= 4'd0;
                        fsm_q <= IDLE;
                    end else if (cnt_q == 4'd0) begin
                        rdata_q <= oor_q ? 32'h0 : mem[idx_q];
                        ready_q <= 1'b1;
                        error_q <= oor_q;
                        fsm_q   <= RESPOND;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                RESPOND: begin
                    fsm_q <= DRAIN;
                end
                DRAIN: begin
                    // Wait for the core to drop enable so a held request is not re-read.
                    if (!data_memory_interface_enable)
                        fsm_q <= IDLE;
                end
                default: begin
                    fsm_q <= IDLE;
                end
            endcase
        end
    end

    assign data_memory_interface_read_data = rdata_q;
    assign data_memory_interface_ready     = ready_q;
    assign data_memory_interface_error     = error_q;

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller: vector table plus
// hand-written sequences for hold, abort, perturbation and reset.
module tb_data_memory_controller;

    localparam int DEPTH = 1024;
    localparam int LAT   = 4;

    logic        clk;
    logic        reset;
    logic        en;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rdy;
    logic        err;

    int n_chk;
    int n_fail;
    logic [31:0] last_rd;

    data_memory_controller #(
        .DEPTH(DEPTH),
        .READ_LATENCY(LAT)
    ) dut (
        .clk(clk),
        .reset(reset),
        .data_memory_interface_enable(en),
        .data_memory_interface_state(st),
        .data_memory_interface_address(addr),
        .data_memory_interface_frame_mask(mask),
        .data_memory_interface_write_data(wdata),
        .data_memory_interface_read_data(rdata),
        .data_memory_interface_ready(rdy),
        .data_memory_interface_error(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [3:0]  m;
        logic [31:0] d;
        logic [31:0] exp;
        logic        e;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic do_write(input string n, input logic [31:0] a,
                            input logic [3:0] m, input logic [31:0] d,
                            input logic e);
        @(negedge clk);
        en = 1'b1; st = 1'b1; addr = a; mask = m; wdata = d;
        @(negedge clk);
        chk({n, " err"}, 32'(err), 32'(e));
        chk({n, " rdy"}, 32'(rdy), 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk({n, " err clr"}, 32'(err), 32'd0);
    endtask

    task automatic do_read(input string n, input logic [31:0] a,
                           input logic [31:0] exp_d, input logic exp_e,
                           input int hold);
        int k;
        int pulses;
        bit got;
        got = 0;
        k = -1;
        @(negedge clk);
        en = 1'b1; st = 1'b0; addr = a;
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            if (rdy) begin
                got = 1;
                k = i;
                break;
            end
        end
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s timeout: no ready within 20 cycles", n);
        end else begin
            chk({n, " latency"}, 32'(k), 32'(LAT));
            chk({n, " data"}, rdata, exp_d);
            chk({n, " err"}, 32'(err), 32'(exp_e));
        end
        last_rd = exp_d;
        pulses = 0;
        for (int h = 0; h < hold; h++) begin
            if (h == 0) begin
                st = 1'b1; mask = 4'hF; wdata = 32'h0;
            end
            @(negedge clk);
            if (rdy) pulses++;
        end
        if (hold > 0)
            chk({n, " hold pulses"}, 32'(pulses), 32'd0);
        en = 1'b0;
        st = 1'b0;
        @(negedge clk);
        chk({n, " rdy drop"}, 32'(rdy), 32'd0);
        chk({n, " held data"}, rdata, exp_d);
    endtask

    initial begin
        int pulses;
        int k;
        bit got;
        n_chk = 0;
        n_fail = 0;
        last_rd = 32'h0;
        reset = 1'b0; en = 1'b0; st = 1'b0;
        addr = 32'h0; mask = 4'h0; wdata = 32'h0;

        vt.push_back('{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0});
        vt.push_back('{1'b0, 32'h10,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0});
        vt.push_back('{1'b1, 32'h20,   4'hF, 32'h11223344, 32'h0,        1'b0});
        vt.push_back('{1'b1, 32'h20,   4'h9, 32'hAABBCCDD, 32'h0,        1'b0});
        vt.push_back('{1'b0, 32'h20,   4'h0, 32'h0,        32'hAA2233DD, 1'b0});
        vt.push_back('{1'b1, 32'h24,   4'hF, 32'h01020304, 32'h0,        1'b0});
        vt.push_back('{1'b1, 32'h24,   4'h0, 32'hFFFFFFFF, 32'h0,        1'b0});
        vt.push_back('{1'b0, 32'h24,   4'h0, 32'h0,        32'h01020304, 1'b0});
        vt.push_back('{1'b1, 32'h28,   4'hF, 32'h00000000, 32'h0,        1'b0});
        vt.push_back('{1'b1, 32'h28,   4'h6, 32'hCAFEBABE, 32'h0,        1'b0});
        vt.push_back('{1'b0, 32'h28,   4'h0, 32'h0,        32'h00FEBA00, 1'b0});
        vt.push_back('{1'b1, 32'hFFC,  4'hF, 32'h5A5A5A5A, 32'h0,        1'b0});
        vt.push_back('{1'b0, 32'hFFC,  4'h0, 32'h0,        32'h5A5A5A5A, 1'b0});
        vt.push_back('{1'b1, 32'h0,    4'hF, 32'h0BADF00D, 32'h0,        1'b0});
        vt.push_back('{1'b1, 32'h4000, 4'hF, 32'h12345678, 32'h0,        1'b1});
        vt.push_back('{1'b0, 32'h4000, 4'h0, 32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b0, 32'h0,    4'h0, 32'h0,        32'h0BADF00D, 1'b0});
        vt.push_back('{1'b1, 32'h1000, 4'hF, 32'h77777777, 32'h0,        1'b1});
        vt.push_back('{1'b0, 32'h1000, 4'h0, 32'h0,        32'h0,        1'b1});
        vt.push_back('{1'b0, 32'h80000010, 4'h0, 32'h0,    32'h0,        1'b1});
        vt.push_back('{1'b0, 32'h13,   4'h0, 32'h0,        32'hDEADBEEF, 1'b0});

        repeat (3) @(negedge clk);
        chk("reset rdy", 32'(rdy), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset data", rdata, 32'h0);
        reset = 1'b1;

        foreach (vt[i]) begin
            if (vt[i].wr)
                do_write($sformatf("vec%0d wr", i), vt[i].a, vt[i].m,
                         vt[i].d, vt[i].e);
            else
                do_read($sformatf("vec%0d rd", i), vt[i].a, vt[i].exp,
                        vt[i].e, 0);
        end

        // Enable held past ready, with a write attempt while draining.
        do_read("hold", 32'h10, 32'hDEADBEEF, 1'b0, 3);
        do_read("after hold", 32'h10, 32'hDEADBEEF, 1'b0, 0);

        // Address/state changes during READ_WAIT are ignored.
        @(negedge clk);
        en = 1'b1; st = 1'b0; addr = 32'h10;
        @(negedge clk);
        addr = 32'h20; st = 1'b1; mask = 4'hF; wdata = 32'h0;
        got = 0;
        k = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (rdy) begin
                got = 1;
                k = i;
                break;
            end
        end
        chk("perturb got", 32'(got), 32'd1);
        chk("perturb latency", 32'(k), 32'(LAT));
        chk("perturb data", rdata, 32'hDEADBEEF);
        last_rd = 32'hDEADBEEF;
        en = 1'b0; st = 1'b0;
        repeat (2) @(negedge clk);
        do_read("perturb no wr", 32'h20, 32'hAA2233DD, 1'b0, 0);

        // Abort by dropping enable in READ_WAIT.
        @(negedge clk);
        en = 1'b1; st = 1'b0; addr = 32'h10;
        repeat (2) @(negedge clk);
        en = 1'b0;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("abort pulses", 32'(pulses), 32'd0);
        chk("abort data", rdata, last_rd);
        do_read("after abort", 32'h28, 32'h00FEBA00, 1'b0, 0);

        // Reset two edges into a read, with a coincident write.
        @(negedge clk);
        en = 1'b1; st = 1'b0; addr = 32'h10;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        st = 1'b1; mask = 4'hF; wdata = 32'h0;
        @(negedge clk);
        chk("mid rst rdy", 32'(rdy), 32'd0);
        chk("mid rst err", 32'(err), 32'd0);
        chk("mid rst data", rdata, 32'h0);
        reset = 1'b1;
        en = 1'b0; st = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy) pulses++;
        end
        chk("post rst pulses", 32'(pulses), 32'd0);
        chk("post rst data", rdata, 32'h0);
        do_read("post rst", 32'h10, 32'hDEADBEEF, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
